// File: rtl/branch_recovery_ctrl_if.sv
// branch_recovery_ctrl_if: branch resolution inputs and recovery outputs of the misprediction recovery controller.
interface branch_recovery_ctrl_if #(
    parameter int ROB_TAG_BITS  = 5,
    parameter int GHR_BITS      = 10,
    parameter int RAS_CKPT_BITS = 9
);
    logic                     res0_valid, res0_mispred, res0_taken;
    logic [ROB_TAG_BITS-1:0]  res0_tag;
    logic [31:0]              res0_correct_pc;
    logic [GHR_BITS-1:0]      res0_ghr;
    logic [RAS_CKPT_BITS-1:0] res0_ras_ckpt;
    logic                     res1_valid, res1_mispred, res1_taken;
    logic [ROB_TAG_BITS-1:0]  res1_tag;
    logic [31:0]              res1_correct_pc;
    logic [GHR_BITS-1:0]      res1_ghr;
    logic [RAS_CKPT_BITS-1:0] res1_ras_ckpt;
    logic [ROB_TAG_BITS-1:0]  rob_head_tag;
    logic                     flush_valid, fetch_stall, ras_recover, ghr_restore_valid, redirect_valid, busy;
    logic [ROB_TAG_BITS-1:0]  flush_tag;
    logic [RAS_CKPT_BITS-1:0] ras_recover_checkpoint;
    logic [GHR_BITS-1:0]      ghr_restore_value;
    logic [31:0]              redirect_pc, recover_count;

    modport master (
        output res0_valid, res0_mispred, res0_taken, res0_tag, res0_correct_pc, res0_ghr, res0_ras_ckpt,
        output res1_valid, res1_mispred, res1_taken, res1_tag, res1_correct_pc, res1_ghr, res1_ras_ckpt,
        output rob_head_tag,
        input  flush_valid, fetch_stall, ras_recover, ghr_restore_valid, redirect_valid, busy,
        input  flush_tag, ras_recover_checkpoint, ghr_restore_value, redirect_pc, recover_count
    );
    modport slave (
        input  res0_valid, res0_mispred, res0_taken, res0_tag, res0_correct_pc, res0_ghr, res0_ras_ckpt,
        input  res1_valid, res1_mispred, res1_taken, res1_tag, res1_correct_pc, res1_ghr, res1_ras_ckpt,
        input  rob_head_tag,
        output flush_valid, fetch_stall, ras_recover, ghr_restore_valid, redirect_valid, busy,
        output flush_tag, ras_recover_checkpoint, ghr_restore_value, redirect_pc, recover_count
    );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// branch_recovery_ctrl: picks the oldest mispredicted branch and sequences flush, RAS/GHR restore and fetch redirect.
module branch_recovery_ctrl #(
    parameter int ROB_TAG_BITS  = 5,
    parameter int GHR_BITS      = 10,
    parameter int RAS_CKPT_BITS = 9,
    parameter int FLUSH_CYCLES  = 2
) (
    input logic clk,
    input logic rst,
    branch_recovery_ctrl_if.slave io
);
    typedef enum logic [1:0] {IDLE, FLUSH, RESTORE, REDIRECT} state_t;
    state_t                   state;
    logic [2:0]               cnt;
    logic [ROB_TAG_BITS-1:0]  pend_tag, age0, age1, pend_age, win_tag, win_age;
    logic [31:0]              pend_pc, win_pc;
    logic                     pend_taken, win_taken, c0, c1, pick1, accept;
    logic [GHR_BITS-1:0]      pend_ghr, win_ghr;
    logic [RAS_CKPT_BITS-1:0] pend_ckpt, win_ckpt;

    // Ages are relative to the ROB head so tag wrap-around orders correctly.
    assign c0       = io.res0_valid & io.res0_mispred;
    assign c1       = io.res1_valid & io.res1_mispred;
    assign age0     = io.res0_tag - io.rob_head_tag;
    assign age1     = io.res1_tag - io.rob_head_tag;
    assign pend_age = pend_tag - io.rob_head_tag;
    assign pick1    = c1 & (~c0 | (age1 < age0));
    assign win_tag  = pick1 ? io.res1_tag : io.res0_tag;
    assign win_age  = pick1 ? age1 : age0;
    assign win_pc   = pick1 ? io.res1_correct_pc : io.res0_correct_pc;
    assign win_taken = pick1 ? io.res1_taken : io.res0_taken;
    assign win_ghr  = pick1 ? io.res1_ghr : io.res0_ghr;
    assign win_ckpt = pick1 ? io.res1_ras_ckpt : io.res0_ras_ckpt;
    assign accept   = (c0 | c1) & (state == IDLE || win_age < pend_age);
    assign io.busy  = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            pend_tag <= '0;
            pend_pc <= '0;
            pend_taken <= 1'b0;
            pend_ghr <= '0;
            pend_ckpt <= '0;
            io.flush_valid <= 1'b0;
            io.fetch_stall <= 1'b0;
            io.ras_recover <= 1'b0;
            io.ghr_restore_valid <= 1'b0;
            io.redirect_valid <= 1'b0;
            io.flush_tag <= '0;
            io.ras_recover_checkpoint <= '0;
            io.ghr_restore_value <= '0;
            io.redirect_pc <= '0;
            io.recover_count <= '0;
        end else if (accept) begin
            state <= FLUSH;
            cnt <= 3'(FLUSH_CYCLES);
            pend_tag <= win_tag;
            pend_pc <= win_pc;
            pend_taken <= win_taken;
            pend_ghr <= win_ghr;
            pend_ckpt <= win_ckpt;
            io.flush_valid <= 1'b1;
            io.fetch_stall <= 1'b1;
            io.ras_recover <= 1'b0;
            io.ghr_restore_valid <= 1'b0;
            io.redirect_valid <= 1'b0;
            io.flush_tag <= win_tag;
            io.recover_count <= io.recover_count + {31'd0, ~&io.recover_count};
        end else begin
            case (state)
                FLUSH: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= RESTORE;
                        io.flush_valid <= 1'b0;
                        io.ras_recover <= 1'b1;
                        io.ghr_restore_valid <= 1'b1;
                        io.ras_recover_checkpoint <= pend_ckpt;
                        io.ghr_restore_value <= GHR_BITS'({pend_ghr, pend_taken});
                    end
                end
                RESTORE: begin
                    state <= REDIRECT;
                    io.ras_recover <= 1'b0;
                    io.ghr_restore_valid <= 1'b0;
                    io.fetch_stall <= 1'b0;
                    io.redirect_valid <= 1'b1;
                    io.redirect_pc <= pend_pc;
                end
                REDIRECT: begin
                    state <= IDLE;
                    io.redirect_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
